// File: rtl/vecseq_pkg.sv
// Shared types, default parameters and the vector-word split helper for vector_sequencer.
package vecseq_pkg;

  localparam int NIN_DEF           = 3;
  localparam int NOUT_DEF          = 1;
  localparam int AW_DEF            = 14;
  localparam int ECW_DEF           = 32;
  localparam int RST_CYCLES_DEF    = 3;
  localparam int SETTLE_CYCLES_DEF = 1;

  // Widest vector word the split helper handles (NIN+NOUT must not exceed this).
  localparam int VEC_MAXW = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUTRST,
    S_FETCH,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } vecseq_state_t;

  typedef struct packed {
    logic [VEC_MAXW-1:0] ins;
    logic [VEC_MAXW-1:0] exp;
  } vec_fields_t;

  // Word layout is {inputs, expected}; both fields come back right-justified.
  function automatic vec_fields_t vec_split(input logic [VEC_MAXW-1:0] word, input int nout);
    vec_fields_t f;
    f.ins = word >> nout;
    f.exp = word & ({VEC_MAXW{1'b1}} >> (VEC_MAXW - nout));
    return f;
  endfunction

endpackage

// File: rtl/vector_sequencer_if.sv
// Vector-memory read port and DUT drive/observe bus owned by vector_sequencer.
interface vector_sequencer_if
  import vecseq_pkg::*;
#(
  parameter int NIN  = NIN_DEF,
  parameter int NOUT = NOUT_DEF,
  parameter int AW   = AW_DEF
);
  logic                 vec_rd;
  logic [AW-1:0]        vec_addr;
  logic [NIN+NOUT-1:0]  vec_data;
  logic                 dut_rst;
  logic [NIN-1:0]       dut_in;
  logic [NOUT-1:0]      dut_out;

  modport master (output vec_rd, vec_addr, dut_rst, dut_in, input vec_data, dut_out);
  modport slave  (input vec_rd, vec_addr, dut_rst, dut_in, output vec_data, dut_out);
endinterface

// File: rtl/vecseq_sat_counter.sv
// W-bit up counter with synchronous clear that holds at all-ones instead of wrapping.
module vecseq_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments so every register updates together at the edge.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/vector_sequencer.sv
// Self-test controller: holds the DUT in reset, applies stored vectors, counts mismatches.
// Optional VECSEQ_FIRST_FAIL_EN adds ff_valid/ff_addr reporting the first failing vector.
module vector_sequencer
  import vecseq_pkg::*;
#(
  parameter int NIN           = NIN_DEF,
  parameter int NOUT          = NOUT_DEF,
  parameter int AW            = AW_DEF,
  parameter int ECW           = ECW_DEF,
  parameter int RST_CYCLES    = RST_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [AW-1:0]       num_vectors,
  vector_sequencer_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ECW-1:0]      errors
`ifdef VECSEQ_FIRST_FAIL_EN
  ,
  output logic                ff_valid,
  output logic [AW-1:0]       ff_addr
`endif
);

  localparam int TMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  vecseq_state_t   state, state_next;
  logic [AW-1:0]   n_q;
  logic [AW-1:0]   addr_q;
  logic [NIN-1:0]  dut_in_q;
  logic [NOUT-1:0] exp_q;
  logic [TW-1:0]   tmr_cnt;
  logic            tmr_inc, tmr_clr;
  logic            err_inc, run_clr;
  logic            mismatch, last_vec;
  vec_fields_t     split;

  assign split    = vec_split(VEC_MAXW'(bus.vec_data), NOUT);
  assign mismatch = (bus.dut_out != exp_q);
  assign last_vec = (addr_q == n_q - AW'(1));

  // Shared saturating counter doubles as the DUTRST/SETTLE interval timer.
  vecseq_sat_counter #(.W(TW)) u_timer (
    .clk(clk), .reset(reset), .clr(tmr_clr), .inc(tmr_inc), .count(tmr_cnt)
  );

  vecseq_sat_counter #(.W(ECW)) u_errors (
    .clk(clk), .reset(reset), .clr(run_clr), .inc(err_inc), .count(errors)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    tmr_inc    = 1'b0;
    err_inc    = 1'b0;
    run_clr    = 1'b0;
    unique case (state)
      S_IDLE: if (start) begin
        run_clr    = 1'b1;
        state_next = S_DUTRST;
      end
      S_DUTRST: begin
        if (tmr_cnt == TW'(RST_CYCLES - 1)) state_next = (n_q == '0) ? S_DONE : S_FETCH;
        else                                tmr_inc    = 1'b1;
      end
      S_FETCH:  state_next = S_APPLY;
      S_APPLY:  state_next = S_SETTLE;
      S_SETTLE: begin
        if (tmr_cnt == TW'(SETTLE_CYCLES - 1)) state_next = S_CHECK;
        else                                   tmr_inc    = 1'b1;
      end
      S_CHECK: begin
        err_inc    = mismatch;
        state_next = last_vec ? S_DONE : S_FETCH;
      end
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    tmr_clr = (state_next != state);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      n_q      <= '0;
      addr_q   <= '0;
      dut_in_q <= '0;
      exp_q    <= '0;
      pass     <= 1'b0;
    end else begin
      if (run_clr) begin
        n_q    <= num_vectors;
        addr_q <= '0;
        pass   <= 1'b0;
      end
      if (state == S_APPLY) begin
        dut_in_q <= split.ins[NIN-1:0];
        exp_q    <= split.exp[NOUT-1:0];
      end
      if (state == S_CHECK && !last_vec) addr_q <= addr_q + AW'(1);
      if (state == S_DONE)               pass   <= (errors == '0);
    end
  end

`ifdef VECSEQ_FIRST_FAIL_EN
  always_ff @(posedge clk) begin
    if (!reset || run_clr) begin
      ff_valid <= 1'b0;
      ff_addr  <= '0;
    end else if (err_inc && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_addr  <= addr_q;
    end
  end
`endif

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign bus.vec_rd   = (state == S_FETCH);
  assign bus.vec_addr = addr_q;
  assign bus.dut_in   = dut_in_q;
  // DUT stays in reset whenever no run is active.
  assign bus.dut_rst  = (state == S_IDLE) || (state == S_DUTRST);

endmodule
